// File: rtl/ysyx_22050019_pkg.sv
// Shared types and constants for the ysyx_22050019 write-back unit.
package ysyx_22050019_pkg;

   localparam int DATA_WIDTH = 64;

   // Load access size, as encoded by the execute/memory stage.
   typedef enum logic [1:0] {
      LD_B = 2'd0,
      LD_H = 2'd1,
      LD_W = 2'd2,
      LD_D = 2'd3
   } ld_size_e;

   // Write-back sequencing states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } wbu_state_e;

endpackage

// File: rtl/ysyx_22050019_load_ext.sv
// Load data extraction: picks the addressed lane out of an aligned
// doubleword and sign- or zero-extends it to 64 bits. Misaligned low
// address bits are simply dropped; no fault is raised here.
module ysyx_22050019_load_ext
   import ysyx_22050019_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  addr,
   input  ld_size_e    size,
   input  logic        uns,
   output logic [63:0] data
);

   logic [2:0]  lane;
   logic [63:0] shifted;

   // Lane select, shift the addressed bytes down, then extend.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      lane    = 3'd0;
      data    = '0;
      case (size)
         LD_B:    lane = addr;
         LD_H:    lane = {addr[2:1], 1'b0};
         LD_W:    lane = {addr[2], 2'b00};
         default: lane = 3'd0;
      endcase
      shifted = rdata >> {lane, 3'b000};
      case (size)
         LD_B:    data = uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
         LD_H:    data = uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
         LD_W:    data = uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/ysyx_22050019_wbu.sv
// Write-back unit: retires instructions into the integer register file,
// waiting for load data where needed, and pulses commit for difftest.
module ysyx_22050019_wbu #(
   parameter int DATA_WIDTH = ysyx_22050019_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_rd_wen,
   input  logic [DATA_WIDTH-1:0] in_res,
   input  logic                  in_is_load,
   input  logic [1:0]            in_ld_size,
   input  logic                  in_ld_uns,
   input  logic                  mem_rvalid,
   output logic                  mem_rready,
   input  logic [63:0]           mem_rdata,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  commit_valid,
   output logic [DATA_WIDTH-1:0] commit_pc,
   output logic                  busy_rd_valid,
   output logic [ADDR_WIDTH-1:0] busy_rd
);

   import ysyx_22050019_pkg::*;

   wbu_state_e            state;
   logic [DATA_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic                  wen_q;
   logic [2:0]            addr_q;
   ld_size_e              size_q;
   logic                  uns_q;
   logic [63:0]           ld_data;

   assign in_ready   = (state != WAIT_MEM);
   assign mem_rready = (state == WAIT_MEM);

   ysyx_22050019_load_ext u_load_ext (
      .rdata (mem_rdata),
      .addr  (addr_q),
      .size  (size_q),
      .uns   (uns_q),
      .data  (ld_data)
   );

   // Sequencer: accept, optionally wait for load data, then retire for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         pc_q          <= '0;
         rd_q          <= '0;
         wen_q         <= 1'b0;
         addr_q        <= '0;
         size_q        <= LD_B;
         uns_q         <= 1'b0;
         rf_wen        <= 1'b0;
         rf_waddr      <= '0;
         rf_wdata      <= '0;
         commit_valid  <= 1'b0;
         commit_pc     <= '0;
         busy_rd_valid <= 1'b0;
         busy_rd       <= '0;
      end else begin
         // NOTE: state and registered outputs use non-blocking assignment so every read sees the pre-edge value.
         case (state)
            WAIT_MEM: begin
               // Hold indefinitely until the load beat arrives.
               if (mem_rvalid) begin
                  state        <= WRITE;
                  rf_wen       <= wen_q && (rd_q != '0);
                  rf_waddr     <= rd_q;
                  rf_wdata     <= ld_data;
                  commit_valid <= 1'b1;
                  commit_pc    <= pc_q;
               end
            end
            default: begin
               // IDLE or WRITE: the retire pulse drops unless a new non-load follows.
               state         <= IDLE;
               rf_wen        <= 1'b0;
               commit_valid  <= 1'b0;
               busy_rd_valid <= 1'b0;
               busy_rd       <= '0;
               if (in_valid) begin
                  pc_q          <= in_pc;
                  rd_q          <= in_rd;
                  wen_q         <= in_rd_wen;
                  addr_q        <= in_res[2:0];
                  size_q        <= ld_size_e'(in_ld_size);
                  uns_q         <= in_ld_uns;
                  busy_rd_valid <= in_rd_wen && (in_rd != '0);
                  busy_rd       <= (in_rd_wen && (in_rd != '0)) ? in_rd : '0;
                  if (in_is_load) begin
                     state <= WAIT_MEM;
                  end else begin
                     state        <= WRITE;
                     rf_wen       <= in_rd_wen && (in_rd != '0);
                     rf_waddr     <= in_rd;
                     rf_wdata     <= in_res;
                     commit_valid <= 1'b1;
                     commit_pc    <= in_pc;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050019_wbu.sv
// Scoreboard bench for the write-back unit: the driver pushes the expected
// retirement of every accepted instruction, the monitor pops and compares
// whenever commit_valid is seen.
module tb_ysyx_22050019_wbu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_pc = '0;
   logic [4:0]  in_rd = '0;
   logic        in_rd_wen = 1'b0;
   logic [63:0] in_res = '0;
   logic        in_is_load = 1'b0;
   logic [1:0]  in_ld_size = '0;
   logic        in_ld_uns = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic        mem_rready;
   logic [63:0] mem_rdata = '0;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic        busy_rd_valid;
   logic [4:0]  busy_rd;

   typedef struct {
      logic [63:0] pc;
      logic [4:0]  rd;
      logic        wen;
      logic [63:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;

   ysyx_22050019_wbu dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pc         (in_pc),
      .in_rd         (in_rd),
      .in_rd_wen     (in_rd_wen),
      .in_res        (in_res),
      .in_is_load    (in_is_load),
      .in_ld_size    (in_ld_size),
      .in_ld_uns     (in_ld_uns),
      .mem_rvalid    (mem_rvalid),
      .mem_rready    (mem_rready),
      .mem_rdata     (mem_rdata),
      .rf_wen        (rf_wen),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .commit_valid  (commit_valid),
      .commit_pc     (commit_pc),
      .busy_rd_valid (busy_rd_valid),
      .busy_rd       (busy_rd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference load result from the architectural rule: aligned lane, mask, extend.
   function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                            input int size, input bit uns);
      int          nbytes;
      int          off;
      logic [63:0] v;
      logic [63:0] mask;
      nbytes = 1 << size;
      off    = (int'(addr % 8) / nbytes) * nbytes;
      v      = rdata >> (off * 8);
      if (nbytes < 8) begin
         mask = (64'd1 << (nbytes * 8)) - 64'd1;
         v    = v & mask;
         if (!uns && v[nbytes*8-1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic step();
      @(negedge clk);
   endtask

   // Issue one instruction at the current negedge; returns at the negedge of its write cycle.
   task automatic send(input bit is_load, input logic [4:0] rd, input bit wen,
                       input logic [63:0] pc, input logic [63:0] res, input int size,
                       input bit uns, input logic [63:0] rdata, input int delay);
      exp_t e;
      check("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
      in_valid   = 1'b1;
      in_is_load = is_load;
      in_rd      = rd;
      in_rd_wen  = wen;
      in_pc      = pc;
      in_res     = res;
      in_ld_size = size[1:0];
      in_ld_uns  = uns;
      // Stray memory beat at issue time must be ignored.
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = {$urandom, $urandom};
      e.pc   = pc;
      e.rd   = rd;
      e.wen  = wen && (rd != 0);
      e.data = is_load ? ref_load(rdata, res, size, uns) : res;
      sb.push_back(e);
      step();
      in_valid   = 1'b0;
      mem_rvalid = 1'b0;
      check("busy_rd_valid_after_accept", {63'd0, busy_rd_valid}, {63'd0, e.wen});
      if (e.wen) check("busy_rd_after_accept", {59'd0, busy_rd}, {59'd0, rd});
      if (!is_load) begin
         check("alu_commit_next_cycle", {63'd0, commit_valid}, 64'd1);
      end else begin
         check("load_no_commit_in_wait", {63'd0, commit_valid}, 64'd0);
         for (int i = 0; i < delay; i++) begin
            check("in_ready_low_wait", {63'd0, in_ready}, 64'd0);
            check("mem_rready_wait", {63'd0, mem_rready}, 64'd1);
            // Present a new instruction under backpressure; it must not be taken.
            in_valid = 1'($urandom_range(0, 1));
            step();
            check("busy_rd_valid_wait", {63'd0, busy_rd_valid}, {63'd0, e.wen});
         end
         in_valid = 1'b0;
         check("in_ready_low_beat", {63'd0, in_ready}, 64'd0);
         mem_rvalid = 1'b1;
         mem_rdata  = rdata;
         step();
         mem_rvalid = 1'b0;
         mem_rdata  = {$urandom, $urandom};
         check("load_commit_after_beat", {63'd0, commit_valid}, 64'd1);
         check("busy_rd_valid_write", {63'd0, busy_rd_valid}, {63'd0, e.wen});
      end
   endtask

   // Monitor: compare every retirement against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rf_wen && !commit_valid) check("rf_wen_without_commit", 64'd1, 64'd0);
         if (commit_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_commit", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("commit_pc", commit_pc, e.pc);
               check("rf_wen", {63'd0, rf_wen}, {63'd0, e.wen});
               check("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
               check("rf_wdata", rf_wdata, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) step();
      // Reset state.
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      check("reset_rf_wen", {63'd0, rf_wen}, 64'd0);
      check("reset_commit_valid", {63'd0, commit_valid}, 64'd0);
      check("reset_busy_rd_valid", {63'd0, busy_rd_valid}, 64'd0);
      check("reset_outputs", {rf_wdata | commit_pc}, 64'd0);
      check("reset_addrs", {54'd0, rf_waddr, busy_rd}, 64'd0);
      rst_n = 1'b1;
      step();
      check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

      // Back-to-back ALU ops.
      send(0, 5'd5, 1, 64'h8000_0000, 64'h11, 0, 0, 64'd0, 0);
      send(0, 5'd6, 1, 64'h8000_0004, 64'h22, 0, 0, 64'd0, 0);
      step();
      check("idle_after_alu", {63'd0, commit_valid}, 64'd0);

      // lb / lbu with three-cycle memory delay.
      send(1, 5'd8, 1, 64'h8000_0008, 64'h1003, 0, 0, 64'h0000_0000_8000_0000, 3);
      send(1, 5'd9, 1, 64'h8000_000c, 64'h1003, 0, 1, 64'h0000_0000_8000_0000, 3);
      // lw / lwu / ld on the upper word.
      send(1, 5'd10, 1, 64'h8000_0010, 64'h2004, 2, 0, 64'h8765_4321_0000_0000, 0);
      send(1, 5'd11, 1, 64'h8000_0014, 64'h2004, 2, 1, 64'h8765_4321_0000_0000, 1);
      send(1, 5'd12, 1, 64'h8000_0018, 64'h2000, 3, 1, 64'h8765_4321_0000_0000, 0);
      // ALU to x0: commit without write, never busy.
      send(0, 5'd0, 1, 64'h8000_001c, 64'hDEAD, 0, 0, 64'd0, 0);
      check("rd0_no_busy", {63'd0, busy_rd_valid}, 64'd0);
      // Load to x7: busy from accept through write, cleared after.
      send(1, 5'd7, 1, 64'h8000_0020, 64'h3006, 1, 0, 64'h1234_8001_5678_9abc, 2);
      step();
      check("busy_clear_after_write", {63'd0, busy_rd_valid}, 64'd0);

      // Reset during WAIT_MEM abandons the load.
      in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd3; in_rd_wen = 1'b1;
      in_pc = 64'h8000_0100; in_res = 64'h40; in_ld_size = 2'd3;
      step();
      in_valid = 1'b0;
      check("in_wait_before_reset", {63'd0, mem_rready}, 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("reset_mid_wait_in_ready", {63'd0, in_ready}, 64'd1);
      check("reset_mid_wait_busy", {63'd0, busy_rd_valid}, 64'd0);
      mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
      step();
      mem_rvalid = 1'b0;
      check("stray_rvalid_no_commit", {63'd0, commit_valid}, 64'd0);
      check("stray_rvalid_no_wen", {63'd0, rf_wen}, 64'd0);
      check("stray_rvalid_in_ready", {63'd0, in_ready}, 64'd1);

      // Randomised traffic with idle gaps and stray beats.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            in_valid   = 1'b0;
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = {$urandom, $urandom};
            step();
            mem_rvalid = 1'b0;
            check("idle_no_commit", {63'd0, commit_valid}, 64'd0);
         end
         send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
              {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end
      step();
      step();
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
